// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_t   - fetch FSM states
//   fetch_entry_t - one prefetch queue entry {inst, pc, err}
//   IFU_XLEN      - default address width
//   IFU_RESET_PC  - default first fetch address after reset
package ifu_pkg;

    localparam int unsigned IFU_XLEN = 32;
    localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DROP,
        S_HALT
    } ifu_state_t;

    typedef struct packed {
        logic [31:0]         inst;
        logic [IFU_XLEN-1:0] pc;
        logic                err;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO for fetched instructions.
//   clk, rst_n       - clock, asynchronous active-low reset
//   flush            - empties the queue (pointers and count to 0); wins over push/pop
//   push, push_data  - write one entry (caller guarantees not full)
//   pop              - drop the head entry (caller guarantees not empty)
//   head_data        - current head entry, read straight from storage registers
//   count            - number of valid entries
module fetch_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit with a prefetch queue.
//   clk, rst_n                         - clock, asynchronous active-low reset
//   redirect_valid, redirect_pc        - flush queue and restart fetch at redirect_pc
//   mem_req_valid/addr/ready           - fetch request handshake (one outstanding max)
//   mem_rsp_valid/data/err             - response for the outstanding request
//   ifu_valid, ifu_data, ifu_err       - queue head {inst, pc} and its fault flag
//   idu_ready                          - consumer pops the head when ifu_valid && idu_ready
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = IFU_XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              mem_req_valid,
    output logic [XLEN-1:0]   mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic              ifu_valid,
    output logic [32+XLEN-1:0] ifu_data,
    output logic              ifu_err,
    input  logic              idu_ready
);

    localparam int unsigned EW = 32 + XLEN + 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    ifu_state_t      state_reg;
    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] req_pc_reg;
    logic            mem_req_valid_reg;

    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   fifo_head;
    logic            fifo_push;
    logic            fifo_pop;
    logic [XLEN-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // A response that lands in a redirect cycle belongs to the old stream.
    assign fifo_push = (state_reg == S_WAIT_RSP) && mem_rsp_valid && !redirect_valid;
    assign ifu_valid = (fifo_count != '0) && !redirect_valid;
    assign fifo_pop  = ifu_valid && idu_ready;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data ({mem_rsp_data, req_pc_reg, mem_rsp_err}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign ifu_data      = fifo_head[EW-1:1];
    assign ifu_err       = fifo_head[0];
    assign mem_req_valid = mem_req_valid_reg;
    assign mem_req_addr  = fetch_pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= S_IDLE;
            fetch_pc_reg      <= RESET_PC;
            req_pc_reg        <= '0;
            mem_req_valid_reg <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_reg      <= redirect_pc_aligned;
            mem_req_valid_reg <= 1'b0;
            // Any request the memory has already taken must have its
            // response swallowed in S_DROP before a new fetch may start.
            case (state_reg)
                S_REQ:      state_reg <= mem_req_ready ? S_DROP : S_IDLE;
                S_WAIT_RSP: state_reg <= mem_rsp_valid ? S_IDLE : S_DROP;
                S_DROP:     state_reg <= mem_rsp_valid ? S_IDLE : S_DROP;
                default:    state_reg <= S_IDLE;
            endcase
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // Issuing only below DEPTH reserves the slot for the response.
                    if (fifo_count < CW'(DEPTH)) begin
                        state_reg         <= S_REQ;
                        mem_req_valid_reg <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        req_pc_reg        <= fetch_pc_reg;
                        fetch_pc_reg      <= fetch_pc_reg + XLEN'(4);
                        state_reg         <= S_WAIT_RSP;
                        mem_req_valid_reg <= 1'b0;
                    end
                end
                S_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        state_reg <= mem_rsp_err ? S_HALT : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (mem_rsp_valid) begin
                        state_reg <= S_IDLE;
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg         <= S_IDLE;
                    mem_req_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed tests for ifu_prefetch with a behavioural
// single-outstanding memory (instruction word = ~address).
module tb_ifu_prefetch;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              mem_req_valid;
    logic [XLEN-1:0]   mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;
    logic              mem_rsp_err;
    logic              ifu_valid;
    logic [32+XLEN-1:0] ifu_data;
    logic              ifu_err;
    logic              idu_ready;

    ifu_prefetch #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_err    (mem_rsp_err),
        .ifu_valid      (ifu_valid),
        .ifu_data       (ifu_data),
        .ifu_err        (ifu_err),
        .idu_ready      (idu_ready)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Memory model state. n_req counts accepted requests since time 0;
    // err_target is the absolute request number that gets a fault.
    int          mem_lat    = 1;
    int          err_target = -1;
    int          n_req      = 0;
    int          n_base     = 0;
    bit          acc_seen, acc_err, pend, pend_err;
    logic [31:0] acc_addr, pend_addr;
    int          wait_cnt;

    logic [31:0] pcs[$];
    logic [31:0] insts[$];
    logic        errs[$];

    // Accepts are sampled mid-low-phase, after the bench has driven inputs.
    // The response is driven #1 after the edge, mem_lat cycles after accept.
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        pend          = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            acc_seen = 1'b0;
            if (rst_n === 1'b1 && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
                acc_seen = 1'b1;
                n_req++;
                acc_addr = mem_req_addr;
                acc_err  = (n_req == err_target);
                $display("[TB] mem accept #%0d addr=%h", n_req - n_base, mem_req_addr);
            end
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
            mem_rsp_data  = '0;
            if (rst_n !== 1'b1) begin
                pend = 1'b0;
            end else begin
                if (acc_seen) begin
                    pend      = 1'b1;
                    pend_addr = acc_addr;
                    pend_err  = acc_err;
                    wait_cnt  = mem_lat;
                end
                if (pend) begin
                    wait_cnt--;
                    if (wait_cnt <= 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = ~pend_addr;
                        mem_rsp_err   = pend_err;
                        pend          = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b1;
        idu_ready      = 1'b0;
        mem_lat        = 1;
        err_target     = -1;
        pcs.delete();
        insts.delete();
        errs.delete();
        repeat (2) @(negedge clk);
        n_base = n_req;
        rst_n  = 1'b1;
    endtask

    // Sample the head at the negedge; a pop happens on the following edge.
    task automatic collect(input int want, input int budget);
        for (int c = 0; c < budget && pcs.size() < want; c++) begin
            @(negedge clk);
            if (ifu_valid && idu_ready) begin
                pcs.push_back(ifu_data[XLEN-1:0]);
                insts.push_back(ifu_data[XLEN+31:XLEN]);
                errs.push_back(ifu_err);
                $display("[TB] pop pc=%h inst=%h err=%0b", ifu_data[XLEN-1:0], ifu_data[XLEN+31:XLEN], ifu_err);
            end
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b1;
        idu_ready      = 1'b0;
        mem_lat        = 1;
        err_target     = -1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
        tests_run++;
        if (ifu_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ifu_valid: got %b want 0", ifu_valid); end
        tests_run++;
        if (ifu_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ifu_err: got %b want 0", ifu_err); end
        tests_run++;
        if (ifu_data !== '0) begin tests_failed++; $display("FAIL reset_ifu_data: got %h want 0", ifu_data); end
        tests_run++;
        if (mem_req_addr !== RST_PC) begin tests_failed++; $display("FAIL reset_req_addr: got %h want %h", mem_req_addr, RST_PC); end
        n_base = n_req;
        rst_n  = 1'b1;
        #1;
        tests_run++;
        if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL release_cycle1_valid: got %b want 0", mem_req_valid); end
        @(negedge clk);
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            tests_failed++; $display("FAIL release_cycle2_req: got valid=%b addr=%h want 1/%h", mem_req_valid, mem_req_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        idu_ready = 1'b1;
        collect(3, 60);
        idu_ready = 1'b0;
        tests_run++;
        if (pcs.size() != 3) begin tests_failed++; $display("FAIL seq_timeout: got %0d pops want 3", pcs.size()); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (pcs[i] !== RST_PC + 32'(4 * i) || insts[i] !== ~(RST_PC + 32'(4 * i)) || errs[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL seq_entry%0d: got pc=%h inst=%h err=%b want pc=%h inst=%h err=0",
                         i, pcs[i], insts[i], errs[i], RST_PC + 32'(4 * i), ~(RST_PC + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_queue_full();
        do_reset();
        repeat (30) @(negedge clk);
        tests_run++;
        if (n_req - n_base != 4) begin tests_failed++; $display("FAIL full_req_count: got %0d want 4", n_req - n_base); end
        tests_run++;
        if (mem_req_valid !== 1'b0 || ifu_valid !== 1'b1 || ifu_data[XLEN-1:0] !== RST_PC) begin
            tests_failed++; $display("FAIL full_state: got req=%b valid=%b pc=%h want 0/1/%h", mem_req_valid, ifu_valid, ifu_data[XLEN-1:0], RST_PC);
        end
        idu_ready = 1'b1;
        @(negedge clk);
        idu_ready = 1'b0;
        repeat (15) @(negedge clk);
        tests_run++;
        if (n_req - n_base != 5) begin tests_failed++; $display("FAIL full_refill_count: got %0d want 5", n_req - n_base); end
        tests_run++;
        if (mem_req_valid !== 1'b0 || ifu_data[XLEN-1:0] !== RST_PC + 32'd4) begin
            tests_failed++; $display("FAIL full_after_pop: got req=%b pc=%h want 0/%h", mem_req_valid, ifu_data[XLEN-1:0], RST_PC + 32'd4);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_4000;
        #1;
        tests_run++;
        if (ifu_valid !== 1'b0) begin tests_failed++; $display("FAIL redirect_masks_valid: got %b want 0", ifu_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (ifu_valid !== 1'b0) begin tests_failed++; $display("FAIL redirect_flushes_queue: got %b want 0", ifu_valid); end
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0, seen_rsp = 1'b0, early_valid = 1'b0;
        do_reset();
        mem_lat = 4;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = (mem_req_valid === 1'b1);
        end
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1003;
        mem_lat        = 1;
        @(negedge clk);
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (mem_rsp_valid === 1'b1) seen_rsp = 1'b1;
            if (ifu_valid !== 1'b0) early_valid = 1'b1;
            found = (mem_req_valid === 1'b1);
        end
        tests_run++;
        if (!found || !seen_rsp) begin tests_failed++; $display("FAIL rdw_new_req_after_stale_rsp: got req=%b rsp_seen=%b want 1/1", found, seen_rsp); end
        tests_run++;
        if (mem_req_addr !== 32'h8000_1000) begin tests_failed++; $display("FAIL rdw_addr: got %h want 80001000", mem_req_addr); end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = (ifu_valid === 1'b1);
            if (!found && mem_rsp_valid !== 1'b1 && ifu_valid !== 1'b0) early_valid = 1'b1;
        end
        tests_run++;
        if (early_valid) begin tests_failed++; $display("FAIL rdw_stale_push: got early ifu_valid=1 want 0"); end
        tests_run++;
        if (!found || ifu_data[XLEN-1:0] !== 32'h8000_1000 || ifu_data[XLEN+31:XLEN] !== ~32'h8000_1000) begin
            tests_failed++; $display("FAIL rdw_entry: got valid=%b data=%h want 1/%h", found, ifu_data, {~32'h8000_1000, 32'h8000_1000});
        end
    endtask

    task automatic test_redirect_req();
        bit found = 1'b0;
        do_reset();
        mem_req_ready = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = (mem_req_valid === 1'b1);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            tests_failed++; $display("FAIL stall_hold: got valid=%b addr=%h want 1/%h", mem_req_valid, mem_req_addr, RST_PC);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if (mem_req_valid !== 1'b0 || n_req - n_base != 0) begin
            tests_failed++; $display("FAIL withdraw: got valid=%b accepts=%0d want 0/0", mem_req_valid, n_req - n_base);
        end
        @(negedge clk);
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_2000) begin
            tests_failed++; $display("FAIL fresh_req: got valid=%b addr=%h want 1/80002000", mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = (ifu_valid === 1'b1);
        end
        tests_run++;
        if (!found || ifu_data[XLEN-1:0] !== 32'h8000_2000) begin
            tests_failed++; $display("FAIL fresh_entry: got valid=%b pc=%h want 1/80002000", found, ifu_data[XLEN-1:0]);
        end
    endtask

    task automatic test_error_halt();
        do_reset();
        err_target = n_base + 3;
        idu_ready  = 1'b1;
        collect(3, 60);
        tests_run++;
        if (pcs.size() != 3) begin tests_failed++; $display("FAIL err_timeout: got %0d pops want 3", pcs.size()); end
        tests_run++;
        if (errs[0] !== 1'b0 || errs[1] !== 1'b0) begin tests_failed++; $display("FAIL err_clean_entries: got %b%b want 00", errs[0], errs[1]); end
        tests_run++;
        if (errs[2] !== 1'b1 || pcs[2] !== RST_PC + 32'd8) begin
            tests_failed++; $display("FAIL err_entry: got err=%b pc=%h want 1/%h", errs[2], pcs[2], RST_PC + 32'd8);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (n_req - n_base != 3 || mem_req_valid !== 1'b0) begin
            tests_failed++; $display("FAIL err_halt: got accepts=%0d valid=%b want 3/0", n_req - n_base, mem_req_valid);
        end
        err_target     = -1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_3000;
        @(negedge clk);
        redirect_valid = 1'b0;
        pcs.delete();
        insts.delete();
        errs.delete();
        collect(1, 30);
        idu_ready = 1'b0;
        tests_run++;
        if (pcs.size() != 1 || pcs[0] !== 32'h8000_3000 || errs[0] !== 1'b0) begin
            tests_failed++; $display("FAIL err_resume: got pops=%0d pc=%h err=%b want 1/80003000/0", pcs.size(), pcs[0], errs[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit found = 1'b0;
        do_reset();
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            found = (dut.fifo_count == 2) && (mem_rsp_valid === 1'b1);
        end
        idu_ready = 1'b1;
        @(negedge clk);
        idu_ready = 1'b0;
        tests_run++;
        if (!found || dut.fifo_count !== 3'd2) begin
            tests_failed++; $display("FAIL push_pop_count: got found=%b count=%0d want 1/2", found, dut.fifo_count);
        end
        tests_run++;
        if (ifu_data[XLEN-1:0] !== RST_PC + 32'd4) begin
            tests_failed++; $display("FAIL push_pop_head: got %h want %h", ifu_data[XLEN-1:0], RST_PC + 32'd4);
        end
        for (int c = 0; c < 300 && pcs.size() < 10; c++) begin
            @(negedge clk);
            idu_ready = (c % 3 != 1);
            if (ifu_valid && idu_ready) begin
                pcs.push_back(ifu_data[XLEN-1:0]);
                insts.push_back(ifu_data[XLEN+31:XLEN]);
                $display("[TB] pop pc=%h inst=%h", ifu_data[XLEN-1:0], ifu_data[XLEN+31:XLEN]);
            end
        end
        idu_ready = 1'b0;
        tests_run++;
        if (pcs.size() != 10) begin tests_failed++; $display("FAIL wrap_timeout: got %0d pops want 10", pcs.size()); end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (pcs[i] !== RST_PC + 32'(4 + 4 * i) || insts[i] !== ~(RST_PC + 32'(4 + 4 * i))) begin
                tests_failed++;
                $display("FAIL wrap_order%0d: got pc=%h inst=%h want pc=%h", i, pcs[i], insts[i], RST_PC + 32'(4 + 4 * i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_queue_full();
        test_redirect_wait();
        test_redirect_req();
        test_error_halt();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
